// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// fetch_sequencer_pkg : shared widths, reset PC and FSM encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

  localparam int INSTR_W = 8;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = 16;

  // Location 0 is reserved, so execution begins at 1.
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : PC owner, memory latency wait and valid/ready delivery
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int                MEM_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pccounter,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               idle,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [1:0] c_wait_init = 2'(MEM_LATENCY - 1);

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [1:0]         r_wait, w_wait_nxt;
  logic               r_single, w_single_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [ADDR_W-1:0]  r_ipc, w_ipc_nxt;
  logic               r_valid, w_valid_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_idle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_wait   <= 2'd0;
      r_single <= 1'b0;
      r_instr  <= '0;
      r_ipc    <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_idle   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_wait   <= w_wait_nxt;
      r_single <= w_single_nxt;
      r_instr  <= w_instr_nxt;
      r_ipc    <= w_ipc_nxt;
      r_valid  <= w_valid_nxt;
      r_count  <= w_count_nxt;
      r_idle   <= (w_state_nxt == IDLE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_wait_nxt   = r_wait;
    w_single_nxt = r_single;
    w_instr_nxt  = r_instr;
    w_ipc_nxt    = r_ipc;
    w_valid_nxt  = r_valid;
    w_count_nxt  = r_count;

    case (r_state)
      IDLE: begin
        if (run || step) begin
          w_state_nxt  = ISSUE;
          w_single_nxt = step & ~run;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
        w_wait_nxt  = c_wait_init;
      end
      WAIT: begin
        if (r_wait == 2'd0) begin
          w_instr_nxt = instr_in;
          w_ipc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_wait_nxt = r_wait - 2'd1;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          w_valid_nxt = 1'b0;
          w_count_nxt = r_count + 1'b1;
          w_pc_nxt    = r_pc + 1'b1;
          if (run && !r_single) begin
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt  = IDLE;
            w_single_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Redirect overrides everything except a handshake already counted above.
    if (redirect_valid) begin
      w_pc_nxt    = redirect_addr;
      w_valid_nxt = 1'b0;
      w_instr_nxt = r_instr;
      w_ipc_nxt   = r_ipc;
      if (r_state != IDLE) begin
        w_state_nxt = ISSUE;
      end
    end
  end

  assign pccounter   = r_pc;
  assign instr_out   = r_instr;
  assign instr_pc    = r_ipc;
  assign instr_valid = r_valid;
  assign idle        = r_idle;
  assign fetch_count = r_count;

endmodule

`default_nettype wire
